cmd_arb: RTL
============

Name: cmd_arb

Overview:
- Arbiter and sequencer in front of the command processor's single cmd/cmd_rdy/clr_cmd_rdy/send_resp interface.
- Shares that interface between two requesters: the host (BLE UART wrapper) and the tour move generator.
- Presents one command at a time and holds it stable until the command completes.
- Routes the completion response back to whichever requester issued the command, and times out hung commands.

Parameters:
TMO_CYC, 250_000_000, cycles in WAIT_RESP before a command is abandoned (5 s at 50 MHz); benches override it small.
TOUR_OPC, 4'h4, opcode that completes on consume, because the command processor sends no response for it.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, synchronous, active-high; one clock, all state cleared on the sampling edge
host_cmd  in  16  command from the host
host_cmd_rdy  in  1  host command valid
host_clr_cmd_rdy  out  1  1-cycle pulse: host command consumed
host_resp  out  1  1-cycle pulse: host command finished (drives the UART response)
tour_cmd  in  16  command from the tour move generator
tour_cmd_rdy  in  1  tour command valid
tour_clr_cmd_rdy  out  1  1-cycle pulse: tour command consumed
tour_resp  out  1  1-cycle pulse: tour command finished
tour_active  in  1  high while a tour is in progress
cmd  out  16  command presented to the command processor
cmd_rdy  out  1  command valid to the command processor
clr_cmd_rdy  in  1  command processor has consumed cmd
send_resp  in  1  command processor has finished the command
busy  out  1  high in any state other than IDLE
src  out  1  granted source: 0 = host, 1 = tour
tmo_err  out  1  1-cycle pulse when a command times out

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; cmd register is 16'h0000; state is IDLE; timeout counter is 0.
- Reset mid-operation aborts the command immediately. No resp or tmo_err pulse is generated.
- States: IDLE, ISSUE, WAIT_RESP, GAP.
- IDLE, grant priority:
  - If tour_active=1 and tour_cmd_rdy=1, grant tour.
  - Else if tour_active=0 and host_cmd_rdy=1, grant host.
  - Host requests are held (not consumed) while tour_active=1.
  - Tour requests are held while tour_active=0.
  - With both rdy and tour_active=0, host wins.
- On grant, at the edge ending IDLE cycle N:
  - Latch the selected command into cmd and set src.
  - Go to ISSUE.
- Cycle N+1: cmd_rdy=1, and the granted source's clr_cmd_rdy is high for exactly this cycle.
- ISSUE:
  - cmd_rdy stays high until clr_cmd_rdy is sampled high. cmd_rdy is 0 the cycle after.
  - If cmd[15:12]==TOUR_OPC, go to GAP with no response pulse.
  - Otherwise go to WAIT_RESP and clear the timeout counter.
  - send_resp is ignored in ISSUE.
- WAIT_RESP:
  - cmd_rdy=0; cmd is held stable, because the command processor keeps sampling cmd fields mid-move.
  - The counter increments each cycle.
  - On send_resp=1: pulse host_resp or tour_resp (per src) the next cycle, then go to GAP.
  - If the counter reaches TMO_CYC-1 without send_resp: pulse tmo_err, go to GAP, no resp pulse.
  - If send_resp and timeout occur in the same cycle, send_resp wins.
- GAP: one cycle, lets the requester drop rdy; then go to IDLE. No grant is possible in GAP.
- send_resp outside WAIT_RESP is ignored (no pulse).
- tour_active changes after grant do not affect the in-flight command.
- cmd updates only on grant. The latched value is held through IDLE until the next grant.

Test Plan:
- Host single command: host_cmd=16'h2003, host_cmd_rdy at cycle 10 → cycle 11: cmd=16'h2003, cmd_rdy=1, host_clr_cmd_rdy=1 for one cycle. clr_cmd_rdy at 15 → cmd_rdy=0 at 16. send_resp at 40 → host_resp=1 at 41 only; busy=0 at 43.
- Priority: tour_active=1, both rdy with tour_cmd=16'h23F1 → tour granted, src=1, tour_clr_cmd_rdy pulses, host_clr_cmd_rdy stays 0. Host is granted only after tour_active=0.
- Tour opcode: host_cmd=16'h4000 granted; clr_cmd_rdy after 3 cycles → no WAIT_RESP, no resp pulse, busy clears 2 cycles after clr_cmd_rdy.
- Timeout: TMO_CYC=100, host_cmd=16'h0000, clr_cmd_rdy given, no send_resp → tmo_err pulses once ~100 cycles into WAIT_RESP, host_resp stays 0, IDLE 2 cycles later.
- Stray/simultaneous: send_resp pulse in IDLE and in ISSUE → no resp. send_resp on the exact timeout cycle → resp pulse, no tmo_err.
- Reset mid-move: rst=1 for one cycle while in WAIT_RESP → next cycle all outputs 0, cmd=0, state IDLE; a later send_resp produces no pulse.

Source files
------------

// File: rtl/cmd_arb.sv
// Two-requester arbiter in front of the command processor. It grants one command at a
// time, holds it stable until completion, routes the response back and times out hangs.
module cmd_arb #(
  parameter int unsigned TMO_CYC  = 250_000_000,
  parameter logic [3:0]  TOUR_OPC = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] host_cmd,
  input  logic        host_cmd_rdy,
  output logic        host_clr_cmd_rdy,
  output logic        host_resp,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  output logic        tour_clr_cmd_rdy,
  output logic        tour_resp,
  input  logic        tour_active,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        busy,
  output logic        src,
  output logic        tmo_err
);

  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fin, fin_nxt;
  logic [15:0]   cmd_nxt;
  logic          src_nxt, cmd_rdy_nxt;
  logic          host_clr_nxt, tour_clr_nxt, host_resp_nxt, tour_resp_nxt, tmo_nxt;

  // Handshake: cmd_rdy rises with the grant and falls the cycle after clr_cmd_rdy is
  // sampled high; every other output toward a requester is a one-cycle pulse.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    fin_nxt       = 1'b0;
    cmd_nxt       = cmd;
    src_nxt       = src;
    cmd_rdy_nxt   = cmd_rdy;
    host_clr_nxt  = 1'b0;
    tour_clr_nxt  = 1'b0;
    host_resp_nxt = 1'b0;
    tour_resp_nxt = 1'b0;
    tmo_nxt       = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy_nxt = 1'b0;
        if (tour_active && tour_cmd_rdy) begin
          cmd_nxt      = tour_cmd;
          src_nxt      = 1'b1;
          tour_clr_nxt = 1'b1;
          cmd_rdy_nxt  = 1'b1;
          state_nxt    = ISSUE;
        end else if (!tour_active && host_cmd_rdy) begin
          cmd_nxt      = host_cmd;
          src_nxt      = 1'b0;
          host_clr_nxt = 1'b1;
          cmd_rdy_nxt  = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
          if (cmd[15:12] == TOUR_OPC) begin
            state_nxt = GAP;
          end else begin
            state_nxt = WAIT_RESP;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT_RESP: begin
        // fin marks the cycle the resp/tmo pulse is visible; leave only after it.
        if (fin) begin
          state_nxt = GAP;
        end else if (send_resp) begin
          fin_nxt       = 1'b1;
          host_resp_nxt = ~src;
          tour_resp_nxt = src;
        end else if (cnt == TMO_LAST) begin
          fin_nxt = 1'b1;
          tmo_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      fin              <= 1'b0;
      cmd              <= 16'h0000;
      src              <= 1'b0;
      cmd_rdy          <= 1'b0;
      host_clr_cmd_rdy <= 1'b0;
      tour_clr_cmd_rdy <= 1'b0;
      host_resp        <= 1'b0;
      tour_resp        <= 1'b0;
      tmo_err          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      fin              <= fin_nxt;
      cmd              <= cmd_nxt;
      src              <= src_nxt;
      cmd_rdy          <= cmd_rdy_nxt;
      host_clr_cmd_rdy <= host_clr_nxt;
      tour_clr_cmd_rdy <= tour_clr_nxt;
      host_resp        <= host_resp_nxt;
      tour_resp        <= tour_resp_nxt;
      tmo_err          <= tmo_nxt;
      busy             <= (state_nxt != IDLE);
    end
  end

endmodule
